// File: rtl/hive_io_bridge_pkg.sv
// -----------------------------------------------------------------------------
// hive_io_bridge_pkg
// Shared definitions for the hive I/O bridge: GPIO word field positions and
// the host-to-core handshake state encoding.
// Field map, identical on gpio_i and gpio_o:
//   [31]    word toggle (TGL)
//   [30]    ack toggle  (ACK)
//   [29:27] reserved (driven 0, ignored on input)
//   [26:24] thread
//   [23:0]  payload
// -----------------------------------------------------------------------------
package hive_io_bridge_pkg;

  localparam int TGL_BIT  = 31;
  localparam int ACK_BIT  = 30;
  localparam int THRD_LSB = 24;
  localparam int PLD_LSB  = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } h2c_state_e;

endpackage

// File: rtl/hive_bridge_fifo.sv
// -----------------------------------------------------------------------------
// hive_bridge_fifo
// First-word-fall-through FIFO with occupancy output. DEPTH must be a power of
// two (>= 2) so the pointers wrap naturally.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   push_i, din_i  : write request / data (ignored while full)
//   pop_i          : read request (ignored while empty)
//   dout_o         : head entry, valid whenever valid_o is high
//   valid_o        : FIFO non-empty
//   full_o         : FIFO full
//   lvl_o          : current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module hive_bridge_fifo #(
  parameter int W     = 27,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [W-1:0]     din_i,
  input  logic             pop_i,
  output logic [W-1:0]     dout_o,
  output logic             valid_o,
  output logic             full_o,
  output logic [LVL_W-1:0] lvl_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] lvl;
  logic             do_push;
  logic             do_pop;

  // Push is qualified on the pre-pop fullness, so a full FIFO only drains.
  assign full_o  = (lvl == LVL_W'(DEPTH));
  assign valid_o = (lvl != '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & valid_o;
  assign dout_o  = mem[rd_ptr];
  assign lvl_o   = lvl;

  // Storage carries no reset; only pointers and level define contents.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= din_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   lvl <= lvl + LVL_W'(1);
        2'b01:   lvl <= lvl - LVL_W'(1);
        default: lvl <= lvl;
      endcase
    end
  end

endmodule

// File: rtl/hive_io_bridge.sv
// -----------------------------------------------------------------------------
// hive_io_bridge
// Host-side agent on the core's GPIO/interrupt interface. Converts the 32-bit
// io_o/io_i pair into two toggle-handshake mailboxes with host valid/ready
// streams.
//   Core-to-host: a word is pending when gpio_r[TGL] differs from our ack
//   toggle; it is pushed into a FWFT FIFO and acknowledged by flipping
//   gpio_o[ACK]. While the FIFO is full the ack is withheld and the core stalls.
//   Host-to-core: in IDLE a host word is loaded onto gpio_o[26:0], gpio_o[TGL]
//   flips and the FSM waits in PEND until the core echoes the toggle on its ACK.
// Handshakes: a host stream transfer happens on a clock edge where valid and
// ready are both high; ready never depends on valid.
// Build option: define HIVE_BRIDGE_INTR_EN to pulse intr_o[thread] for one
// cycle on every host-to-core load; otherwise intr_o is tied to 0.
// Ports:
//   clk_i, rst_n_i         : clock, asynchronous active-low reset
//   gpio_i / gpio_o        : from core io_o / to core io_i
//   intr_o                 : to core intr_req_i, one-cycle pulses
//   h_rx_*                 : core-to-host stream (data, thread, valid, ready)
//   h_tx_*                 : host-to-core stream (data, thread, valid, ready)
//   fifo_lvl_o             : core-to-host FIFO occupancy
//   state_o                : host-to-core FSM state (debug)
// -----------------------------------------------------------------------------
module hive_io_bridge
  import hive_io_bridge_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int THREADS    = 8,
  parameter int THRD_W     = 3,
  parameter int PLD_W      = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DATA_W-1:0] gpio_i,
  output logic [DATA_W-1:0] gpio_o,
  output logic [THREADS-1:0] intr_o,
  output logic [PLD_W-1:0]  h_rx_data_o,
  output logic [THRD_W-1:0] h_rx_thrd_o,
  output logic              h_rx_valid_o,
  input  logic              h_rx_ready_i,
  input  logic [PLD_W-1:0]  h_tx_data_i,
  input  logic [THRD_W-1:0] h_tx_thrd_i,
  input  logic              h_tx_valid_i,
  output logic              h_tx_ready_o,
  output logic [LVL_W-1:0]  fifo_lvl_o,
  output h2c_state_e        state_o
);

  localparam int RSV_W  = ACK_BIT - THRD_LSB - THRD_W;
  localparam int ENTRY_W = THRD_W + PLD_W;

  logic [DATA_W-1:0]  gpio_r;
  logic [RSV_W-1:0]   unused_rsvd;
  logic               c2h_ack;
  logic               c2h_push;
  logic               fifo_full;
  logic [ENTRY_W-1:0] fifo_dout;
  logic               h2c_tgl;
  logic               h2c_load;
  logic               sampled;
  logic [THRD_W-1:0]  tx_thrd_q;
  logic [PLD_W-1:0]   tx_data_q;
  h2c_state_e         state;

  assign unused_rsvd = gpio_r[ACK_BIT-1:THRD_LSB+THRD_W];

  // Input register plus a flag marking that gpio_r holds a real sample, so
  // the host is not offered ready on the reset value of gpio_r.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      gpio_r  <= '0;
      sampled <= 1'b0;
    end else begin
      gpio_r  <= gpio_i;
      sampled <= 1'b1;
    end
  end

  // ---------------- core-to-host ----------------
  assign c2h_push = (gpio_r[TGL_BIT] != c2h_ack) && !fifo_full;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      c2h_ack <= 1'b0;
    end else if (c2h_push) begin
      c2h_ack <= ~c2h_ack;
    end
  end

  hive_bridge_fifo #(
    .W     (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (c2h_push),
    .din_i   (gpio_r[THRD_LSB+THRD_W-1:PLD_LSB]),
    .pop_i   (h_rx_valid_o & h_rx_ready_i),
    .dout_o  (fifo_dout),
    .valid_o (h_rx_valid_o),
    .full_o  (fifo_full),
    .lvl_o   (fifo_lvl_o)
  );

  assign h_rx_thrd_o = fifo_dout[ENTRY_W-1:PLD_W];
  assign h_rx_data_o = fifo_dout[PLD_W-1:0];

  // ---------------- host-to-core ----------------
  assign h_tx_ready_o = sampled && (state == ST_IDLE) && (h2c_tgl == gpio_r[ACK_BIT]);
  assign h2c_load     = h_tx_ready_o & h_tx_valid_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= ST_IDLE;
      h2c_tgl   <= 1'b0;
      tx_thrd_q <= '0;
      tx_data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (h2c_load) begin
            tx_thrd_q <= h_tx_thrd_i;
            tx_data_q <= h_tx_data_i;
            h2c_tgl   <= ~h2c_tgl;
            state     <= ST_PEND;
          end
        end
        ST_PEND: begin
          // Payload stays frozen until the core echoes our toggle.
          if (gpio_r[ACK_BIT] == h2c_tgl) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef HIVE_BRIDGE_INTR_EN
  logic [THREADS-1:0] intr_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      intr_q <= '0;
    end else begin
      intr_q <= h2c_load ? (THREADS'(1) << h_tx_thrd_i) : '0;
    end
  end

  assign intr_o = intr_q;
`else
  assign intr_o = '0;
`endif

  assign gpio_o  = {h2c_tgl, c2h_ack, {RSV_W{1'b0}}, tx_thrd_q, tx_data_q};
  assign state_o = state;

endmodule
